// File: rtl/systolic_drain.sv
// systolic_drain: output stage downstream of the systolic PE array.
// On start it snapshots every PE accumulator, pulses clear_acc_o so the array
// can begin its next tile, then streams the snapshot one array row per beat
// over a valid/ready interface. Each lane is requantized on the way out:
// rounding arithmetic right shift, then saturation to OUT_W.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a drain (sampled only in IDLE)
//   shift_amt     requant right-shift amount, latched with start
//   acc_flat      PE accumulators, PE (r,c) at [(r*COLS+c)*ACC_W +: ACC_W]
//   clear_acc_o   one-cycle accumulator clear pulse to the array
//   busy          high while a drain is in progress (CAPTURE/STREAM/DONE)
//   done          one-cycle pulse after the last beat
//   out_valid     beat valid
//   out_ready     downstream ready
//   out_data      requantized row, lane c at [c*OUT_W +: OUT_W]
//   out_row       row index of the current beat
//   out_last      high on the beat for row ROWS-1
module systolic_drain #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SHIFT_W-1:0]            shift_amt,
  input  logic [ROWS*COLS*ACC_W-1:0]    acc_flat,
  output logic                          clear_acc_o,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*OUT_W-1:0]         out_data,
  output logic [ROW_W-1:0]              out_row,
  output logic                          out_last
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  state_t                       state_q, state_d;
  logic [ROWS*COLS*ACC_W-1:0]   snap_q;
  logic [SHIFT_W-1:0]           shift_q;
  logic [ROW_W-1:0]             row_q;
  logic                         is_last;
  logic                         fire;

  // Requantize one accumulator. Working in ACC_W+1 bits keeps the rounding
  // bias from overflowing even for the most positive accumulator.
  function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                                input logic [SHIFT_W-1:0] s);
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] y;
    logic [OUT_W-1:0]      res;
    int                    sh;
    x = signed'({acc[ACC_W-1], acc});
    if (int'(s) >= ACC_W) begin
      sh = ACC_W - 1;
    end else begin
      sh = int'(s);
    end
    if (sh == 0) begin
      y = x;
    end else begin
      bias = {{ACC_W{1'b0}}, 1'b1} << (sh - 1);
      y    = (x + bias) >>> sh;
    end
    if (y > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
    end else if (y < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
    end else begin
      res = y[OUT_W-1:0];
    end
    return res;
  endfunction

  assign is_last = (row_q == LAST_ROW);
  assign fire    = (state_q == S_STREAM) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: state_d = S_STREAM;
      S_STREAM: begin
        if (fire && is_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot, shift amount and row counter. The snapshot is taken on the
  // same edge that accepts start, so the clear pulse that follows cannot
  // reach the data being streamed.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q  <= '0;
      shift_q <= '0;
      row_q   <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      snap_q  <= acc_flat;
      shift_q <= shift_amt;
      row_q   <= '0;
    end else if (fire && !is_last) begin
      row_q   <= row_q + ROW_W'(1);
    end
  end

  assign clear_acc_o = (state_q == S_CAPTURE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign out_valid   = (state_q == S_STREAM);
  assign out_row     = out_valid ? row_q : '0;
  assign out_last    = out_valid && is_last;

  // Requantized row, held at zero outside STREAM.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*OUT_W +: OUT_W] =
          requant(snap_q[(int'(row_q) * COLS + c) * ACC_W +: ACC_W], shift_q);
      end
    end else begin
      out_data = '0;
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 5;
  localparam int ROW_W   = 2;
  localparam int NPE     = ROWS * COLS;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [SHIFT_W-1:0]       shift_amt;
  logic [NPE*ACC_W-1:0]     acc_flat;
  logic                     clear_acc_o;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*OUT_W-1:0]    out_data;
  logic [ROW_W-1:0]         out_row;
  logic                     out_last;

  int n_checks = 0;
  int n_pass   = 0;

  systolic_drain #(
    .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .shift_amt(shift_amt),
    .acc_flat(acc_flat), .clear_acc_o(clear_acc_o), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: round-half-up division by 2^s on an integer, then clamp.
  function automatic logic [OUT_W-1:0] ref_lane(input logic [ACC_W-1:0] acc, input int s);
    longint x, y, lim;
    x = longint'(signed'(acc));
    if (s > ACC_W - 1) s = ACC_W - 1;
    if (s == 0) y = x;
    else        y = (x + (longint'(1) << (s - 1))) >>> s;
    lim = longint'(1) << (OUT_W - 1);
    if (y > lim - 1)   y = lim - 1;
    else if (y < -lim) y = -lim;
    return y[OUT_W-1:0];
  endfunction

  function automatic logic [COLS*OUT_W-1:0] ref_row(input logic [NPE*ACC_W-1:0] a,
                                                     input int s, input int r);
    logic [COLS*OUT_W-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*OUT_W +: OUT_W] = ref_lane(a[(r*COLS+c)*ACC_W +: ACC_W], s);
    return v;
  endfunction

  function automatic logic [NPE*ACC_W-1:0] rand_acc();
    logic [NPE*ACC_W-1:0] a;
    logic [ACC_W-1:0]     v;
    for (int i = 0; i < NPE; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 140000)) - 32'd70000;
        2: v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: v = 32'($urandom_range(0, 2000)) - 32'd1000;
      endcase
      a[i*ACC_W +: ACC_W] = v;
    end
    return a;
  endfunction

  // Full drain checked beat by beat against the reference; chaos mode adds
  // random backpressure and scrambles acc_flat/shift_amt after the snapshot.
  task automatic drain(input string tag, input logic [NPE*ACC_W-1:0] a, input int s, input bit chaos);
    int r;
    int cyc;
    bit rdy;
    acc_flat = a; shift_amt = SHIFT_W'(s); start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " capture"}, {clear_acc_o, busy, out_valid}, 3'b110);
    if (chaos) begin acc_flat = rand_acc(); shift_amt = SHIFT_W'($urandom); end
    tick();
    r = 0; cyc = 0;
    while (r < ROWS && cyc < 64) begin
      check({tag, " beat"}, {out_valid, clear_acc_o, busy, out_row, out_last, out_data},
            {1'b1, 1'b0, 1'b1, ROW_W'(r), r == ROWS - 1, ref_row(a, s, r)});
      rdy = chaos ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (chaos) begin acc_flat = rand_acc(); shift_amt = SHIFT_W'($urandom); end
      tick();
      if (rdy) r++;
      cyc++;
    end
    if (cyc >= 64) begin
      n_checks++;
      $display("FAIL %s timeout: drain did not finish in 64 cycles, expected %0d beats", tag, ROWS);
    end
    check({tag, " done"}, {done, busy, out_valid, clear_acc_o}, 4'b1100);
    out_ready = 1'b1;
    tick();
    check({tag, " idle"}, {done, busy, out_valid, clear_acc_o}, 4'b0000);
  endtask

  typedef struct {
    logic [ACC_W-1:0] acc;
    int               sh;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vt[11];
  logic [NPE*ACC_W-1:0] a_bp;
  logic [ROWS*COLS*2+8:0] clr_mask, done_mask, exp_clr, exp_done;

  initial begin
    vt[0]  = '{32'd5,          1,  16'd3};
    vt[1]  = '{-32'sd5,        1,  16'hFFFE};
    vt[2]  = '{-32'sd6,        2,  16'hFFFF};
    vt[3]  = '{32'd7,          2,  16'd2};
    vt[4]  = '{32'h7FFF_FFFF,  31, 16'd1};
    vt[5]  = '{32'h7FFF_FFFF,  0,  16'h7FFF};
    vt[6]  = '{32'h8000_0000,  0,  16'h8000};
    vt[7]  = '{32'd32768,      0,  16'h7FFF};
    vt[8]  = '{-32'sd32769,    0,  16'h8000};
    vt[9]  = '{-32'sd32768,    0,  16'h8000};
    vt[10] = '{32'd100,        0,  16'd100};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; shift_amt = '0; acc_flat = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset idle", {clear_acc_o, busy, done, out_valid, out_data, out_row, out_last}, '0);
    end

    // All accumulators 100, shift 0, ready high: exact cycle timeline.
    drain("basic", {NPE{32'd100}}, 0, 1'b0);

    // Requant table: every PE loaded with the same value, first beat checked.
    for (int i = 0; i < 11; i++) begin
      acc_flat = {NPE{vt[i].acc}}; shift_amt = SHIFT_W'(vt[i].sh);
      start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check($sformatf("requant vec%0d", i), out_data, {COLS{vt[i].exp}});
      for (int k = 0; k < ROWS + 1; k++) tick();
    end

    // Backpressure on row 1 for three cycles, with acc_flat churning.
    a_bp = rand_acc();
    acc_flat = a_bp; shift_amt = 5'd3; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc_flat = rand_acc();
      tick();
      check("backpressure hold", {out_valid, out_row, out_data}, {1'b1, 2'd1, ref_row(a_bp, 3, 1)});
    end
    out_ready = 1'b1;
    tick();
    check("backpressure resume", {out_valid, out_row, out_data}, {1'b1, 2'd2, ref_row(a_bp, 3, 2)});
    tick(); tick(); tick();

    // start pulsed during STREAM and DONE must be ignored.
    acc_flat = rand_acc(); shift_amt = 5'd5; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick();
    out_ready = 1'b0; start = 1'b1;
    tick();
    check("start in stream", {clear_acc_o, out_valid, out_row}, {1'b0, 1'b1, 2'd0});
    start = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("reach done", {done, busy}, 2'b11);
    start = 1'b1;
    tick();
    check("start in done", {clear_acc_o, busy, done}, 3'b000);
    start = 1'b0;
    tick();
    check("still idle", {clear_acc_o, busy}, 2'b00);

    // Reset in the middle of STREAM (row 2): abandoned, no done.
    acc_flat = rand_acc(); shift_amt = 5'd0; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("at row 2", {out_valid, out_row}, {1'b1, 2'd2});
    rst = 1'b1;
    tick();
    check("mid reset", {busy, out_valid, done, clear_acc_o, out_row}, '0);
    rst = 1'b0;
    tick();
    check("after reset", {busy, done, out_valid}, 3'b000);

    // start held high: drains every ROWS+3 cycles, one clear per drain.
    clr_mask = '0; done_mask = '0;
    exp_clr = '0; exp_done = '0;
    for (int d = 0; d < 3; d++) begin
      exp_clr[1 + d*(ROWS+3)]  = 1'b1;
      exp_done[ROWS + 2 + d*(ROWS+3)] = 1'b1;
    end
    acc_flat = rand_acc(); start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 3*(ROWS+3); k++) begin
      tick();
      clr_mask[k]  = clear_acc_o;
      done_mask[k] = done;
    end
    start = 1'b0;
    check("b2b clear cycles", clr_mask, exp_clr);
    check("b2b done cycles", done_mask, exp_done);
    tick(); tick();
    check("b2b idle", {busy, clear_acc_o}, 2'b00);

    // Randomized drains against the reference model.
    for (int k = 0; k < 30; k++) drain("random", rand_acc(), $urandom_range(0, 31), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
